// File: rtl/banked_lane_memory_pkg.sv
// Shared types for the banked lane memory.
// Holds the sweep FSM encoding and the lane-count helper.
package banked_lane_memory_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int lane_count(input int wsize, input int lsize);
        return wsize / lsize;
    endfunction

endpackage

// File: rtl/banked_lane_memory_if.sv
// User-side bus of the banked lane memory: clear, write and read ports.
// The memory is the slave; the driver of requests is the master.
interface banked_lane_memory_if #(
    parameter int wordsize = 8,
    parameter int addrsize = 4,
    parameter int lanes    = 1
);
    logic                clear;
    logic                busy;
    logic                we;
    logic [addrsize-1:0] waddr;
    logic [wordsize-1:0] wdata;
    logic [lanes-1:0]    wbe;
    logic                re;
    logic [addrsize-1:0] raddr;
    logic [wordsize-1:0] rdata;
    logic                rvalid;

    modport master (
        output clear, we, waddr, wdata, wbe, re, raddr,
        input  busy, rdata, rvalid
    );

    modport slave (
        input  clear, we, waddr, wdata, wbe, re, raddr,
        output busy, rdata, rvalid
    );
endinterface

// File: rtl/banked_lane_memory.sv
// Byte-lane writable RAM with registered read-first port and a
// self-clearing sweep that runs after reset and on request.
module banked_lane_memory
    import banked_lane_memory_pkg::*;
#(
    parameter int                 wordsize = 8,
    parameter int                 addrsize = 4,
    parameter int                 lanesize = 8,
    parameter logic [wordsize-1:0] clearval = '0
) (
    input  logic clk,
    input  logic rst_n,
    banked_lane_memory_if.slave bus
);
    localparam int LANES = lane_count(wordsize, lanesize);
    localparam int DEPTH = 2 ** addrsize;
    localparam logic [addrsize-1:0] LAST = '1;

    state_t              r_state;
    state_t              w_next;
    logic [addrsize-1:0] r_cnt;
    logic [wordsize-1:0] r_mem [DEPTH];
    logic [wordsize-1:0] r_rdata;
    logic                r_rvalid;
    logic [wordsize-1:0] w_mask;
    logic [wordsize-1:0] w_merge;
    logic                w_wr;
    logic                w_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= CLEAR;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (bus.clear) w_next = CLEAR;
            CLEAR: if (r_cnt == LAST) w_next = IDLE;
        endcase
    end

    // Counter wraps to zero on the last sweep address, ready for next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_cnt <= '0;
        else if (r_state == CLEAR) r_cnt <= r_cnt + 1'b1;
        else                      r_cnt <= '0;
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            if (bus.wbe[i]) w_mask[i*lanesize +: lanesize] = '1;
        end
    end

    assign w_merge = (r_mem[bus.waddr] & ~w_mask)
                   | (bus.wdata & w_mask);
    assign w_wr    = (r_state == IDLE) && bus.we && (|bus.wbe);
    assign w_rd    = (r_state == IDLE) && bus.re;

    // The array itself carries no reset; the sweep initialises it.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) r_mem[r_cnt]     <= clearval;
        else if (w_wr)        r_mem[bus.waddr] <= w_merge;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= r_mem[bus.raddr];
        end
    end

    assign bus.busy   = (r_state == CLEAR);
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;

endmodule
